// File: rtl/periph_obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave port among per-hart masters.
// One outstanding transaction; a watchdog forces an error response on hang.
package eros_obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module periph_obi_arbiter
  import eros_obi_pkg::*;
#(
  parameter int          NHARTS         = 3,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [NHARTS],
  output obi_resp_t master_resp_o [NHARTS],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      busy_o,
  output logic      timeout_o,
  output logic      stray_rsp_o
);

  localparam int IW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES == 0) ?
                             0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;

  logic            any_req;
  logic [IW-1:0]   win;
  logic [IW-1:0]   sel;
  logic            req_act;
  logic            fire_to;

  function automatic logic [IW-1:0] rr_next(
    input logic [IW-1:0] w
  );
    if (int'(w) + 1 == NHARTS) return '0;
    return w + 1'b1;
  endfunction

  // Rotating scan starting at rr_q; first requester wins.
  always_comb begin
    int idx;
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < NHARTS; k++) begin
      idx = (int'(rr_q) + k) % NHARTS;
      if (!any_req && master_req_i[idx].req) begin
        any_req = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  assign sel = (state_q == ADDR) ? owner_q : win;

  assign req_act = !rst_i &&
                   ((state_q == IDLE && any_req) ||
                    state_q == ADDR);

  assign fire_to = !rst_i &&
                   (TIMEOUT_CYCLES != 0) &&
                   state_q == RESP &&
                   !slave_resp_i.rvalid &&
                   cnt_q == TO_LAST;

  always_comb begin
    slave_req_o = '0;
    if (req_act) begin
      slave_req_o     = master_req_i[sel];
      slave_req_o.req = 1'b1;
    end
  end

  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      master_resp_o[h] = '0;
    end
    if (req_act) begin
      master_resp_o[sel].gnt = slave_resp_i.gnt;
    end
    if (!rst_i && state_q == RESP) begin
      if (slave_resp_i.rvalid) begin
        master_resp_o[owner_q].rvalid = 1'b1;
        master_resp_o[owner_q].rdata  = slave_resp_i.rdata;
      end else if (fire_to) begin
        master_resp_o[owner_q].rvalid = 1'b1;
        master_resp_o[owner_q].rdata  = ERR_RDATA;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign timeout_o   = fire_to;
  assign stray_rsp_o = !rst_i &&
                       state_q != RESP &&
                       slave_resp_i.rvalid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= win;
            if (slave_resp_i.gnt) begin
              rr_q    <= rr_next(win);
              cnt_q   <= '0;
              state_q <= RESP;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          if (slave_resp_i.gnt) begin
            rr_q    <= rr_next(owner_q);
            cnt_q   <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (slave_resp_i.rvalid || fire_to) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_obi_arbiter.sv
// Scoreboarded bench for periph_obi_arbiter: directed OBI traffic,
// expected responses queued at stimulus time, popped on master rvalid.
module tb_periph_obi_arbiter;
  import eros_obi_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  obi_req_t  mreq  [3];
  obi_resp_t mresp [3];
  obi_req_t  sreq;
  obi_resp_t sresp;
  logic      busy, tmo, stray;

  obi_req_t  mreq1  [1];
  obi_resp_t mresp1 [1];
  obi_req_t  sreq1;
  obi_resp_t sresp1;
  logic      busy1, tmo1, stray1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          hart;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  periph_obi_arbiter #(
    .NHARTS(3),
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .master_req_i(mreq),
    .master_resp_o(mresp),
    .slave_req_o(sreq),
    .slave_resp_i(sresp),
    .busy_o(busy),
    .timeout_o(tmo),
    .stray_rsp_o(stray)
  );

  periph_obi_arbiter #(
    .NHARTS(1)
  ) dut1 (
    .clk_i(clk),
    .rst_i(rst),
    .master_req_i(mreq1),
    .master_resp_o(mresp1),
    .slave_req_o(sreq1),
    .slave_resp_i(sresp1),
    .busy_o(busy1),
    .timeout_o(tmo1),
    .stray_rsp_o(stray1)
  );

  task automatic chk(string tag, logic [79:0] got,
                     logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic push(int h, logic [31:0] d);
    exp_t e;
    e.hart = h;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic chk_gnt(string tag, int w);
    for (int h = 0; h < 3; h++) begin
      chk($sformatf("%s_gnt%0d", tag, h),
          80'(mresp[h].gnt), 80'(h == w));
    end
  endtask

  // Scoreboard: any master rvalid must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int h = 0; h < 3; h++) begin
        if (mresp[h].rvalid) begin
          if (sbq.size() == 0) begin
            chk($sformatf("sb_unexp_h%0d", h), 80'd1, 80'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_hart", 80'(h), 80'(e.hart));
            chk("sb_data", 80'(mresp[h].rdata), 80'(e.data));
          end
        end else begin
          chk("rdata_idle", 80'(mresp[h].rdata), 80'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int h = 0; h < 3; h++) mreq[h] = '0;
    mreq1[0] = '0;
    sresp    = '0;
    sresp1   = '0;

    // Reset state
    step;
    sample;
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_tmo", 80'(tmo), 80'd0);
    chk("rst_stray", 80'(stray), 80'd0);
    chk("rst_sreq", 80'(sreq), 80'd0);
    chk("rst_rr", 80'(dut.rr_q), 80'd0);
    step;
    rst = 1'b0;

    // Single read from hart 1
    mreq[1] = '{req: 1'b1, addr: 32'h0001_0000,
                we: 1'b0, be: 4'hf, wdata: 32'h0};
    sresp.gnt = 1'b1;
    sample;
    chk_gnt("t1", 1);
    chk("t1_addr", 80'(sreq.addr), 80'h0001_0000);
    chk("t1_sreq", 80'(sreq.req), 80'd1);
    step;
    mreq[1]      = '0;
    sresp        = '0;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h1234_5678;
    push(1, 32'h1234_5678);
    sample;
    chk_gnt("t1r", -1);
    chk("t1_rv1", 80'(mresp[1].rvalid), 80'd1);
    chk("t1_rr", 80'(dut.rr_q), 80'd2);
    step;
    sresp = '0;
    sample;
    chk("t1_idle", 80'(busy), 80'd0);

    // All harts request continuously from reset
    rst = 1'b1;
    for (int h = 0; h < 3; h++) begin
      mreq[h] = '{req: 1'b1, addr: 32'h1000 * (h + 1),
                  we: 1'b0, be: 4'hf, wdata: 32'h0};
    end
    step;
    sample;
    chk("t2_rst_sreq", 80'(sreq.req), 80'd0);
    chk_gnt("t2_rst", -1);
    step;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sresp     = '0;
      sresp.gnt = 1'b1;
      sample;
      chk_gnt($sformatf("t2a%0d", k), k % 3);
      chk("t2_addr", 80'(sreq.addr),
          80'(32'h1000 * (k % 3 + 1)));
      step;
      sresp.rvalid = 1'b1;
      sresp.rdata  = 32'hA000_0000 + k;
      push(k % 3, 32'hA000_0000 + k);
      sample;
      chk_gnt($sformatf("t2b%0d", k), -1);
      step;
    end
    for (int h = 0; h < 3; h++) mreq[h] = '0;
    sresp = '0;
    step;

    // Held gnt; late request from hart 0 must not steal the slot
    mreq[2] = '{req: 1'b1, addr: 32'h0000_2000,
                we: 1'b1, be: 4'hf, wdata: 32'h2222_0000};
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        mreq[0] = '{req: 1'b1, addr: 32'h0000_0100,
                    we: 1'b0, be: 4'hf, wdata: 32'h0};
      end
      sresp.gnt = (c == 3);
      if (c == 3) push(2, 32'h2222_AAAA);
      sample;
      chk($sformatf("t3_addr%0d", c),
          80'(sreq.addr), 80'h2000);
      chk($sformatf("t3_wdata%0d", c),
          80'(sreq.wdata), 80'h2222_0000);
      chk($sformatf("t3_g2_%0d", c),
          80'(mresp[2].gnt), 80'(c == 3));
      chk($sformatf("t3_g0_%0d", c),
          80'(mresp[0].gnt), 80'd0);
      chk($sformatf("t3_busy%0d", c),
          80'(busy), 80'(c != 0));
      step;
    end
    mreq[2]      = '0;
    sresp        = '0;
    sresp.gnt    = 1'b1;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h2222_AAAA;
    sample;
    chk("t3_resp_req", 80'(sreq.req), 80'd0);
    chk_gnt("t3r", -1);
    step;
    sresp     = '0;
    sresp.gnt = 1'b1;
    push(0, 32'h0000_0B0B);
    sample;
    chk_gnt("t3n", 0);
    chk("t3_addr0", 80'(sreq.addr), 80'h100);
    step;
    mreq[0]      = '0;
    sresp        = '0;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h0000_0B0B;
    sample;
    step;
    sresp = '0;

    // Watchdog fires at grant+4, then a stray rvalid
    mreq[1] = '{req: 1'b1, addr: 32'h0000_3000,
                we: 1'b0, be: 4'hf, wdata: 32'h0};
    sresp.gnt = 1'b1;
    push(1, 32'hDEAD_BEEF);
    sample;
    chk_gnt("t4", 1);
    step;
    mreq[1] = '0;
    sresp   = '0;
    for (int c = 1; c < 4; c++) begin
      sample;
      chk($sformatf("t4_tmo%0d", c), 80'(tmo), 80'd0);
      chk($sformatf("t4_rv%0d", c),
          80'(mresp[1].rvalid), 80'd0);
      chk($sformatf("t4_busy%0d", c), 80'(busy), 80'd1);
      step;
    end
    sample;
    chk("t4_tmo4", 80'(tmo), 80'd1);
    chk("t4_rv4", 80'(mresp[1].rvalid), 80'd1);
    step;
    sample;
    chk("t4_tmo5", 80'(tmo), 80'd0);
    chk("t4_busy5", 80'(busy), 80'd0);
    step;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h5555_5555;
    sample;
    chk("t4_stray6", 80'(stray), 80'd1);
    step;
    sresp = '0;
    sample;
    chk("t4_stray7", 80'(stray), 80'd0);

    // Real rvalid on the watchdog's last cycle wins
    mreq[0] = '{req: 1'b1, addr: 32'h0000_4000,
                we: 1'b0, be: 4'hf, wdata: 32'h0};
    sresp.gnt = 1'b1;
    step;
    mreq[0] = '0;
    sresp   = '0;
    step;
    step;
    step;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h0000_CAFE;
    push(0, 32'h0000_CAFE);
    sample;
    chk("t4b_tmo", 80'(tmo), 80'd0);
    chk("t4b_rv", 80'(mresp[0].rvalid), 80'd1);
    step;
    sresp = '0;

    // Reset while in RESP abandons the transaction
    mreq[0] = '{req: 1'b1, addr: 32'h0000_5000,
                we: 1'b0, be: 4'hf, wdata: 32'h0};
    sresp.gnt = 1'b1;
    sample;
    chk_gnt("t5", 0);
    step;
    mreq[0]      = '0;
    sresp        = '0;
    rst          = 1'b1;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h7777_7777;
    sample;
    chk("t5_rv0", 80'(mresp[0].rvalid), 80'd0);
    step;
    rst   = 1'b0;
    sresp = '0;
    sample;
    chk("t5_busy", 80'(busy), 80'd0);
    chk("t5_sreq", 80'(sreq), 80'd0);
    chk("t5_rr", 80'(dut.rr_q), 80'd0);
    step;
    mreq[0] = '{req: 1'b1, addr: 32'h0000_6000,
                we: 1'b0, be: 4'hf, wdata: 32'h0};
    mreq[1] = '{req: 1'b1, addr: 32'h0000_6100,
                we: 1'b0, be: 4'hf, wdata: 32'h0};
    sresp.gnt = 1'b1;
    push(0, 32'h6666_0000);
    sample;
    chk_gnt("t5n", 0);
    step;
    mreq[0]      = '0;
    mreq[1]      = '0;
    sresp        = '0;
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h6666_0000;
    sample;
    step;
    sresp = '0;

    // Single-master write passes through untouched
    mreq1[0] = '{req: 1'b1, addr: 32'h0000_0040,
                 we: 1'b1, be: 4'b0011, wdata: 32'h0000_ABCD};
    sresp1.gnt = 1'b1;
    sample;
    chk("t6_sreq", 80'(sreq1), 80'(mreq1[0]));
    chk("t6_gnt", 80'(mresp1[0].gnt), 80'd1);
    step;
    mreq1[0]      = '0;
    sresp1        = '0;
    sresp1.rvalid = 1'b1;
    sample;
    chk("t6_rv", 80'(mresp1[0].rvalid), 80'd1);
    chk("t6_busy", 80'(busy1), 80'd1);
    step;
    sresp1 = '0;
    sample;
    chk("t6_idle", 80'(busy1), 80'd0);

    step;
    chk("sb_left", 80'(sbq.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/periph_obi_arbiter.md
# periph_obi_arbiter

Shares the single OBI slave port of the peripheral subsystem (register-bus bridge, address decoder, demux, debug boot ROM) between `NHARTS` OBI masters, one per hart. Arbitration is round-robin. At most one transaction is outstanding at a time. A response-timeout watchdog guarantees that a hung peripheral cannot stall a hart forever. The block sits between the per-hart peripheral-window ports of the bus and `periph_system.slave_req_i/slave_resp_o`.

## Interface
- `NHARTS`, 3: number of masters (≥1).
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in RESP before a forced error response; 0 disables the watchdog.
- `ERR_RDATA`, 32'hDEAD_BEEF: rdata returned on timeout.

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `master_req_i`  in  NHARTS × `eros_obi_pkg::obi_req_t`  per-hart requests (req, addr, we, be, wdata).
- `master_resp_o`  out  NHARTS × `eros_obi_pkg::obi_resp_t`  per-hart gnt, rvalid, rdata.
- `slave_req_o`  out  `obi_req_t`  to peripheral system.
- `slave_resp_i`  in  `obi_resp_t`  from peripheral system.
- `busy_o`  out  1  high when state ≠ IDLE.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.
- `stray_rsp_o`  out  1  one-cycle pulse when slave rvalid arrives outside RESP.

## Operation
- Registers:
  - `state_q` ∈ {IDLE, ADDR, RESP}.
  - `rr_q`: next-priority index, width $clog2(NHARTS), min 1.
  - `owner_q`: same width as `rr_q`.
  - `cnt_q`: width $clog2(TIMEOUT_CYCLES+1), min 1.
- Winner selection (combinational): the first index i with `master_req_i[i].req`, scanning `rr_q`, `rr_q+1`, … modulo NHARTS.
- IDLE:
  - If any request is present, `slave_req_o` carries the winner's fields with req=1, and `master_resp_o[winner].gnt` = `slave_resp_i.gnt`.
  - If gnt is high: `owner_q`←winner, `rr_q`←(winner+1 == NHARTS ? 0 : winner+1), `cnt_q`←0, go to RESP.
  - If gnt is low: `owner_q`←winner, go to ADDR.
  - With no request: `slave_req_o.req`=0 and the other fields are 0.
- ADDR: the owner is locked. `slave_req_o` carries `master_req_i[owner_q]`, and only the owner sees gnt. Newly arriving requests never change the selection. On gnt: update `rr_q` as above, `cnt_q`←0, go to RESP.
- RESP:
  - `slave_req_o.req`=0 and all master gnt=0.
  - On `slave_resp_i.rvalid`: `master_resp_o[owner_q].rvalid`=1 and rdata=`slave_resp_i.rdata` in the same cycle (combinational pass-through), then go to IDLE.
  - Otherwise `cnt_q`++. When `TIMEOUT_CYCLES`≠0 and `cnt_q`==TIMEOUT_CYCLES−1 with no rvalid: drive owner rvalid=1 and rdata=ERR_RDATA, pulse `timeout_o`, go to IDLE.
- Non-owner masters never see rvalid. rdata is 0 whenever rvalid=0.
- A slave rvalid in IDLE or ADDR is discarded and pulses `stray_rsp_o`.
- The masters must hold req and address fields stable until gnt (OBI rule). The block does not check this.
- Reset: state IDLE, `rr_q`=0, `owner_q`=0, `cnt_q`=0.
  - All `master_resp_o` fields, `busy_o`, `timeout_o` and `stray_rsp_o` are 0.
  - `slave_req_o` is 0 unless a master requests in the cycle reset deasserts.
  - A transaction in flight when reset asserts is abandoned with no rvalid to its master.

## Timing
- The request path is combinational: master req → `slave_req_o` with no added cycle, so the grant is same-cycle with a combinational slave gnt.
- The response path is combinational: slave rvalid → master rvalid in the same cycle.
- After rvalid, the block returns to IDLE. The next grant is possible in the following cycle.
- Minimum spacing is 2 cycles per transaction: grant cycle, then response cycle.
- Timeout: with the grant at cycle g and no rvalid, the error rvalid is at cycle g+TIMEOUT_CYCLES.
- A rvalid arriving on the watchdog's last cycle wins: real data is forwarded and there is no timeout pulse.

## Test plan
- Single read, hart 1, addr 0x0001_0000, slave gnt immediate, rvalid +1 with rdata 0x1234_5678 → hart 1 gnt at cycle 0, rvalid with 0x1234_5678 at cycle 1, `rr_q`=2; harts 0 and 2 never see gnt or rvalid.
- Harts 0, 1 and 2 all request continuously from reset → grant order 0,1,2,0,1,2, one grant every 2 cycles.
- Hart 2 requests and slave gnt is held low for 3 cycles; hart 0 raises req in cycle 1 → `slave_req_o` keeps hart 2's addr/wdata throughout; hart 2 is granted at cycle 3; hart 0 is granted in the next IDLE.
- TIMEOUT_CYCLES=4, grant at cycle 0, slave never asserts rvalid → owner gets rvalid with 0xDEAD_BEEF at cycle 4; `timeout_o` is high for 1 cycle; a slave rvalid at cycle 6 pulses `stray_rsp_o` and no master sees it.
- Reset asserted while in RESP → the next cycle is IDLE with all outputs 0; a request after release from hart 0 is granted with `rr_q` starting at 0.
- NHARTS=1 with a write (we=1, be=4'b0011) → passes through unchanged; rvalid is returned to hart 0.
